// File: rtl/mandelbrot_pixel_scan.sv
// Raster scan of the H_RES x V_RES pixel grid, emitting complex coordinates
// built incrementally from latched view parameters over a valid/ready handshake.
module mandelbrot_pixel_scan #(
  parameter int FP_WIDTH = 26,
  parameter int H_RES    = 800,
  parameter int V_RES    = 600,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       init,
  input  logic signed [FP_WIDTH-1:0] step,
  input  logic signed [FP_WIDTH-1:0] x_start,
  input  logic signed [FP_WIDTH-1:0] y_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COL_W-1:0]           out_col,
  output logic [ROW_W-1:0]           out_row,
  output logic signed [FP_WIDTH-1:0] c_re,
  output logic signed [FP_WIDTH-1:0] c_im,
  output logic                       frame_busy,
  output logic                       frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_RES - 1);

  state_t r_state, w_state_nxt;

  logic                       r_valid, r_busy, r_done;
  logic [COL_W-1:0]           r_col;
  logic [ROW_W-1:0]           r_row;
  logic signed [FP_WIDTH-1:0] r_c_re, r_c_im, r_step, r_xs;

  logic                       w_valid_nxt, w_busy_nxt, w_done_nxt;
  logic [COL_W-1:0]           w_col_nxt;
  logic [ROW_W-1:0]           w_row_nxt;
  logic signed [FP_WIDTH-1:0] w_c_re_nxt, w_c_im_nxt, w_step_nxt, w_xs_nxt;

  logic w_hs, w_last_col, w_last_row;

  assign w_hs       = (r_state == S_SCAN) && r_valid && out_ready;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (init) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (init)                                  w_state_nxt = S_SCAN;
        else if (w_hs && w_last_col && w_last_row) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = init ? S_SCAN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // init takes priority over any handshake on the same edge, in every state.
  always_comb begin
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_c_re_nxt  = r_c_re;
    w_c_im_nxt  = r_c_im;
    w_step_nxt  = r_step;
    w_xs_nxt    = r_xs;
    if (init) begin
      w_step_nxt  = step;
      w_xs_nxt    = x_start;
      w_c_re_nxt  = x_start;
      w_c_im_nxt  = y_start;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
      w_valid_nxt = 1'b1;
      w_busy_nxt  = 1'b1;
    end else if (w_hs) begin
      if (!w_last_col) begin
        w_col_nxt  = r_col + COL_W'(1);
        w_c_re_nxt = r_c_re + r_step;
      end else if (!w_last_row) begin
        w_col_nxt  = '0;
        w_row_nxt  = r_row + ROW_W'(1);
        w_c_re_nxt = r_xs;
        w_c_im_nxt = r_c_im - r_step;
      end else begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_c_re  <= '0;
      r_c_im  <= '0;
      r_step  <= '0;
      r_xs    <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_c_re  <= w_c_re_nxt;
      r_c_im  <= w_c_im_nxt;
      r_step  <= w_step_nxt;
      r_xs    <= w_xs_nxt;
    end
  end

  assign out_valid  = r_valid;
  assign frame_busy = r_busy;
  assign frame_done = r_done;
  assign out_col    = r_col;
  assign out_row    = r_row;
  assign c_re       = r_c_re;
  assign c_im       = r_c_im;

endmodule

// File: tb/tb_mandelbrot_pixel_scan.sv
// Bench: a small-grid instance checked cycle by cycle against an index-based
// coordinate model, plus a full-size instance for first-row spot values.
module tb_mandelbrot_pixel_scan;
  localparam int FPW = 26;
  localparam int SH  = 8;
  localparam int SV  = 5;

  logic CLK = 1'b0;
  logic RESET, init, out_ready;
  logic [FPW-1:0] step, x_start, y_start;

  logic           s_valid, s_busy, s_done;
  logic [2:0]     s_col, s_row;
  logic [FPW-1:0] s_re, s_im;
  logic           b_valid, b_busy, b_done;
  logic [9:0]     b_col, b_row;
  logic [FPW-1:0] b_re, b_im;

  always #5 CLK = ~CLK;

  mandelbrot_pixel_scan #(.FP_WIDTH(FPW), .H_RES(SH), .V_RES(SV), .COL_W(3), .ROW_W(3)) u_small (
    .CLK(CLK), .RESET(RESET), .init(init), .step(step), .x_start(x_start), .y_start(y_start),
    .out_valid(s_valid), .out_ready(out_ready), .out_col(s_col), .out_row(s_row),
    .c_re(s_re), .c_im(s_im), .frame_busy(s_busy), .frame_done(s_done));

  mandelbrot_pixel_scan #(.FP_WIDTH(FPW), .H_RES(800), .V_RES(600), .COL_W(10), .ROW_W(10)) u_big (
    .CLK(CLK), .RESET(RESET), .init(init), .step(step), .x_start(x_start), .y_start(y_start),
    .out_valid(b_valid), .out_ready(out_ready), .out_col(b_col), .out_row(b_row),
    .c_re(b_re), .c_im(b_im), .frame_busy(b_busy), .frame_done(b_done));

  int n_chk = 0, n_pass = 0;

  // Reference model of the small instance: indices plus latched view.
  int       m_col, m_row;
  bit       m_valid, m_busy, m_done;
  logic [FPW-1:0] m_step, m_xs, m_ys;
  logic [FPW-1:0] p_step, p_x, p_y;

  logic [FPW*2+5:0] q_full[$], q_rand[$];

  function automatic logic [FPW*2+8:0] dvec();
    return {s_valid, s_busy, s_done, s_col, s_row, s_re, s_im};
  endfunction

  function automatic logic [FPW*2+8:0] evec();
    logic [FPW-1:0] re, im;
    re = m_xs + FPW'(m_col) * m_step;
    im = m_ys - FPW'(m_row) * m_step;
    return {m_valid, m_busy, m_done, 3'(m_col), 3'(m_row), re, im};
  endfunction

  task automatic model_edge(input bit i_init, input bit i_rdy, input bit i_rst);
    if (i_rst) begin
      m_col = 0; m_row = 0; m_valid = 0; m_busy = 0; m_done = 0;
      m_step = '0; m_xs = '0; m_ys = '0;
    end else begin
      m_done = 0;
      if (i_init) begin
        m_step = p_step; m_xs = p_x; m_ys = p_y;
        m_col = 0; m_row = 0; m_valid = 1; m_busy = 1;
      end else if (m_valid && i_rdy) begin
        if (m_col < SH - 1) m_col++;
        else if (m_row < SV - 1) begin m_col = 0; m_row++; end
        else begin m_valid = 0; m_busy = 0; m_done = 1; end
      end
    end
  endtask

  task automatic cyc(input bit i_init, input bit i_rdy, input bit i_rst);
    RESET = i_rst; init = i_init; out_ready = i_rdy;
    if (i_init) begin step = p_step; x_start = p_x; y_start = p_y; end
    else begin step = FPW'($urandom); x_start = FPW'($urandom); y_start = FPW'($urandom); end
    model_edge(i_init, i_rdy, i_rst);
    @(posedge CLK); #1;
    RESET = 1'b0; init = 1'b0;
  endtask

  task automatic new_params();
    p_step = FPW'($urandom); p_x = FPW'($urandom); p_y = FPW'($urandom);
  endtask

  task automatic run_to(input int col, input int row, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (s_valid && s_col == 3'(col) && s_row == 3'(row)) begin ok = 1; break; end
      cyc(0, 1, 0);
    end
  endtask

  task automatic test_reset();
    cyc(0, 0, 1);
    n_chk++; if (dvec() !== evec() || dvec() !== '0) $display("FAIL reset_small act=%h req=%h", dvec(), evec()); else n_pass++;
    n_chk++;
    if ({b_valid, b_busy, b_done, b_col, b_row, b_re, b_im} !== '0)
      $display("FAIL reset_big act=%h req=0", {b_valid, b_busy, b_done, b_col, b_row, b_re, b_im});
    else n_pass++;
  endtask

  task automatic test_first_row();
    p_step = 26'h0001000; p_x = 26'h3E00000; p_y = 26'h012C000;
    cyc(1, 1, 0);
    n_chk++;
    if ({b_valid, b_col, b_row, b_re, b_im} !== {1'b1, 10'd0, 10'd0, 26'h3E00000, 26'h012C000})
      $display("FAIL big_first act=%b %0d %0d %h %h req=1 0 0 3e00000 012c000", b_valid, b_col, b_row, b_re, b_im);
    else n_pass++;
    for (int i = 0; i < 799; i++) cyc(0, 1, 0);
    n_chk++;
    if ({b_valid, b_col, b_row, b_re} !== {1'b1, 10'd799, 10'd0, 26'h011F000})
      $display("FAIL big_799_0 act=%b %0d %0d %h req=1 799 0 011f000", b_valid, b_col, b_row, b_re);
    else n_pass++;
    cyc(0, 1, 0);
    n_chk++;
    if ({b_valid, b_col, b_row, b_re, b_im} !== {1'b1, 10'd0, 10'd1, 26'h3E00000, 26'h012B000})
      $display("FAIL big_0_1 act=%b %0d %0d %h %h req=1 0 1 3e00000 012b000", b_valid, b_col, b_row, b_re, b_im);
    else n_pass++;
    cyc(0, 0, 1);
  endtask

  task automatic test_full_frame();
    int hs = 0, dn = 0;
    new_params();
    cyc(1, 1, 0);
    for (int i = 0; i < 200; i++) begin
      n_chk++; if (dvec() !== evec()) $display("FAIL full_beat act=%h req=%h", dvec(), evec()); else n_pass++;
      if (s_valid) begin hs++; q_full.push_back({s_col, s_row, s_re, s_im}); end
      if (s_done) begin dn++; break; end
      cyc(0, 1, 0);
    end
    n_chk++; if (hs != SH * SV) $display("FAIL full_count act=%0d req=%0d", hs, SH * SV); else n_pass++;
    n_chk++; if (dn != 1 || s_busy || s_valid) $display("FAIL full_done act=%0d/%b/%b req=1/0/0", dn, s_busy, s_valid); else n_pass++;
    cyc(0, 1, 0);
    n_chk++; if (s_done !== 1'b0 || dvec() !== evec()) $display("FAIL done_pulse act=%h req=%h", dvec(), evec()); else n_pass++;
  endtask

  task automatic test_random_ready();
    logic [FPW*2+8:0] prev;
    bit stalled = 0, rdy, ended = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      n_chk++; if (dvec() !== evec()) $display("FAIL rand_beat act=%h req=%h", dvec(), evec()); else n_pass++;
      if (stalled) begin
        n_chk++; if (dvec() !== prev) $display("FAIL stall_hold act=%h req=%h", dvec(), prev); else n_pass++;
      end
      if (s_done) begin ended = 1; break; end
      rdy = 1'($urandom_range(1));
      if (s_valid && rdy) q_rand.push_back({s_col, s_row, s_re, s_im});
      stalled = s_valid && !rdy;
      prev = dvec();
      cyc(0, rdy, 0);
    end
    n_chk++; if (!ended) $display("FAIL rand_timeout act=0 req=1"); else n_pass++;
    n_chk++;
    if (q_rand.size() != q_full.size() || q_rand != q_full)
      $display("FAIL rand_sequence act=%0d beats req=%0d identical beats", q_rand.size(), q_full.size());
    else n_pass++;
    cyc(0, 0, 0);
  endtask

  task automatic test_abort_stall();
    bit ok;
    int dn = 0;
    new_params();
    cyc(1, 1, 0);
    run_to(5, 3, ok);
    n_chk++; if (!ok) $display("FAIL abort_reach act=0 req=1"); else n_pass++;
    cyc(0, 0, 0); cyc(0, 0, 0);
    n_chk++; if (dvec() !== evec()) $display("FAIL abort_stall act=%h req=%h", dvec(), evec()); else n_pass++;
    p_step = 26'h0000400; p_x = FPW'($urandom); p_y = FPW'($urandom);
    cyc(1, 0, 0);
    n_chk++;
    if (!s_valid || s_col !== 3'd0 || s_row !== 3'd0 || s_re !== p_x || s_im !== p_y || s_done || dvec() !== evec())
      $display("FAIL abort_restart act=%h req=%h", dvec(), evec());
    else n_pass++;
    cyc(0, 1, 0);
    n_chk++; if (s_re !== p_x + 26'h0000400) $display("FAIL abort_step act=%h req=%h", s_re, p_x + 26'h0000400); else n_pass++;
    for (int i = 0; i < 200 && s_busy; i++) begin
      if (s_done) dn++;
      cyc(0, 1, 0);
    end
    if (s_done) dn++;
    n_chk++; if (dn != 1) $display("FAIL abort_done_count act=%0d req=1", dn); else n_pass++;
    cyc(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    new_params();
    cyc(1, 1, 0);
    run_to(3, 2, ok);
    n_chk++; if (!ok) $display("FAIL rst_reach act=0 req=1"); else n_pass++;
    cyc(1, 1, 1);
    n_chk++; if (dvec() !== '0 || dvec() !== evec()) $display("FAIL rst_mid act=%h req=0", dvec()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      n_chk++; if (s_valid !== 1'b0 || dvec() !== evec()) $display("FAIL rst_no_beats act=%h req=%h", dvec(), evec()); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ended = 0;
    new_params();
    cyc(1, 1, 0);
    run_to(SH - 1, SV - 1, ok);
    n_chk++; if (!ok) $display("FAIL b2b_reach act=0 req=1"); else n_pass++;
    new_params();
    cyc(1, 1, 0);
    n_chk++;
    if (!s_valid || s_done || !s_busy || s_col !== 3'd0 || s_row !== 3'd0 || dvec() !== evec())
      $display("FAIL b2b_init_last act=%h req=%h", dvec(), evec());
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      if (s_done) begin ended = 1; break; end
      cyc(0, 1, 0);
    end
    n_chk++; if (!ended || dvec() !== evec()) $display("FAIL b2b_finish act=%h req=%h", dvec(), evec()); else n_pass++;
    new_params();
    cyc(1, 0, 0);
    n_chk++;
    if (!s_valid || s_done || s_col !== 3'd0 || s_re !== p_x || dvec() !== evec())
      $display("FAIL init_in_done act=%h req=%h", dvec(), evec());
    else n_pass++;
  endtask

  initial begin
    RESET = 1'b1; init = 1'b0; out_ready = 1'b0;
    step = '0; x_start = '0; y_start = '0;
    p_step = '0; p_x = '0; p_y = '0;
    model_edge(0, 0, 1);
    test_reset();
    test_first_row();
    test_full_frame();
    test_random_ready();
    test_abort_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mandelbrot_pixel_scan.md
Name: mandelbrot_pixel_scan

Overview:
Downstream of the view-coordinate stage. Latches the step, x_start and y_start view parameters when the coordinate stage's one-cycle init pulse arrives. Then walks the H_RES x V_RES pixel grid in raster order, emitting each pixel's complex coordinate (c_re, c_im) plus its column/row index to the iteration engines over a valid/ready handshake. Coordinates are built incrementally by adding or subtracting step; no multipliers are used.

Parameters:
FP_WIDTH, 26, fixed-point width (signed, 20 fractional bits; 1.0 = 2^20)
H_RES, 800, pixels per row
V_RES, 600, rows per frame
COL_W, 10, column index width (must hold H_RES-1)
ROW_W, 10, row index width (must hold V_RES-1)

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
init  input  1  one-cycle pulse: new view parameters valid, restart frame
step  input  FP_WIDTH  signed pixel pitch
x_start  input  FP_WIDTH  signed real coordinate of column 0
y_start  input  FP_WIDTH  signed imaginary coordinate of row 0 (top)
out_valid  output  1  pixel coordinate valid
out_ready  input  1  consumer accepts when out_valid && out_ready
out_col  output  COL_W  pixel column
out_row  output  ROW_W  pixel row
c_re  output  FP_WIDTH  signed real part
c_im  output  FP_WIDTH  signed imaginary part
frame_busy  output  1  high while a frame scan is in progress
frame_done  output  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- One clock (CLK). Reset is synchronous and active-high. Everything is registered.
- Reset values: state IDLE; out_valid=0, frame_busy=0, frame_done=0; out_col=0, out_row=0, c_re=0, c_im=0; latched step=0.
- States: IDLE, SCAN, DONE.
- IDLE: out_valid=0. If init=1 at an edge:
  - latch step;
  - set c_re=x_start, c_im=y_start, out_col=0, out_row=0;
  - set out_valid=1, frame_busy=1; go to SCAN.
  - Latency: first pixel is valid on the cycle after the init edge.
- SCAN, no handshake (out_valid && !out_ready): all outputs hold stable. No output may change while valid is stalled.
- SCAN, handshake with out_col < H_RES-1: out_col+1, c_re += step_latched.
- SCAN, handshake with out_col = H_RES-1 and out_row < V_RES-1:
  - out_col=0, out_row+1;
  - c_re = latched x_start (x_start is latched alongside step);
  - c_im -= step_latched.
- SCAN, handshake on pixel (H_RES-1, V_RES-1): out_valid=0, frame_busy=0, frame_done=1 for exactly one cycle; go to DONE.
- DONE: frame_done returns to 0; go to IDLE next cycle. An init arriving in DONE is honoured exactly as in IDLE.
- init during SCAN (stalled or not) aborts the frame:
  - new parameters latched and indices zeroed;
  - out_valid stays 1 presenting (0,0) with the new c_re/c_im on the next cycle;
  - no frame_done for the aborted frame.
- init and a handshake on the same edge: init wins; the accepted pixel counts as consumed and the scan restarts.
- Arithmetic is two's complement, modulo 2^FP_WIDTH, with no saturation. Step changes outside init have no effect (latched copy only).
- Indices never exceed H_RES-1 / V_RES-1. The row counter never wraps within a frame.
- RESET mid-frame returns to the reset values on the next edge, regardless of init or out_ready.

Test Plan:
- Reset then init with step=26'h0001000, x_start=26'h3E00000, y_start=26'h012C000, out_ready=1 -> first beat (0,0) c_re=26'h3E00000, c_im=26'h012C000 one cycle after init; beat (799,0) c_re=26'h011F000; beat (0,1) c_re=26'h3E00000, c_im=26'h012B000.
- Same frame run to completion -> exactly 480000 handshakes; last beat (799,599) c_im=26'h3ED5000; frame_done high one cycle; frame_busy low; out_valid low.
- Random out_ready (50% duty) -> out_col/out_row/c_re/c_im stable whenever out_valid && !out_ready; beat sequence identical to the full-throughput run.
- init with step=26'h0000400 at pixel (123,45) while stalled -> next cycle (0,0) with the new start values; following c_re increments by 26'h0000400; no frame_done for the aborted frame.
- RESET asserted at pixel (10,10) with out_ready=1 -> next cycle all outputs at reset values; no beats until the next init.
- init coincident with the final handshake of a frame -> no frame_done; new frame starts at (0,0) the next cycle.
